// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain readback path.
package ccff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } ccff_state_e;

   // Number of output words needed to carry chain_len bits.
   function automatic int calc_word_count(input int chain_len, input int word_width);
      return (chain_len + word_width - 1) / word_width;
   endfunction

   // Number of meaningful bits in the final (possibly partial) word.
   function automatic int last_word_bits(input int chain_len, input int word_width);
      return chain_len - (calc_word_count(chain_len, word_width) - 1) * word_width;
   endfunction

   localparam int DEF_CHAIN_LEN  = 64;
   localparam int DEF_WORD_WIDTH = 8;
   localparam int DEF_WORD_COUNT = calc_word_count(DEF_CHAIN_LEN, DEF_WORD_WIDTH);

endpackage

// File: rtl/ccff_word_packer.sv
// Packs serial chain bits LSB-first into a word; presents the word including
// the bit being captured this cycle so the top can load it at the same edge.
module ccff_word_packer
   import ccff_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  capture,
   input  logic                  flush,
   input  logic                  bit_in,
   output logic [WORD_WIDTH-1:0] word_out,
   output logic                  word_full
);

   localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_WIDTH-1:0] pack_q, pack_d;

   // Current pack contents with the incoming bit merged at its slot.
   always_comb begin
      word_out        = pack_q;
      word_out[idx_q] = bit_in;
      word_full       = (idx_q == IDX_W'(WORD_WIDTH - 1));
   end

   // Next pack/index: clear on a new readback or after a word is handed off.
   always_comb begin
      pack_d = pack_q;
      idx_d  = idx_q;
      if (clear) begin
         pack_d = '0;
         idx_d  = '0;
      end else if (capture) begin
         if (word_full || flush) begin
            pack_d = '0;
            idx_d  = '0;
         end else begin
            pack_d = word_out;
            idx_d  = idx_q + IDX_W'(1);
         end
      end
   end

   // Pack register and bit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         pack_q <= '0;
         idx_q  <= '0;
      end else begin
         pack_q <= pack_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/ccff_chain_reader.sv
// Readback end of the ccff chain: shifts the chain, packs tail bits into words
// and hands them out over a valid/ready port.
//
// Handshake: word_data/word_last are held stable while word_valid is high and
// word_ready is low; a word transfers on an edge where word_valid && word_ready.
// A new word may load on the same edge as a transfer (word_valid stays high).
module ccff_chain_reader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
   input  logic                  prog_clk,
   input  logic                  pReset,
   input  logic                  start,
   input  logic                  ccff_tail,
   output logic                  ccff_shift_en,
   output logic [WORD_WIDTH-1:0] word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  word_last,
   output logic                  busy,
   output logic                  done,
   output ccff_state_e           dbg_state
);

   localparam int WORD_COUNT = calc_word_count(CHAIN_LEN, WORD_WIDTH);
   localparam int WCNT_W     = $clog2(WORD_COUNT + 1);

   ccff_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  bitcnt_q, bitcnt_d;
   logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
   logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
   logic                  word_valid_q, word_valid_d;
   logic                  word_last_q, word_last_d;
   logic                  done_q, done_d;

   logic                  capture, handshake, last_bit, load, pk_clear, pk_full;
   logic [WORD_WIDTH-1:0] pk_word;

   // Shift gating, handshake and word-completion decode.
   always_comb begin
      ccff_shift_en = !pReset && (state_q == SHIFT) && (!word_valid_q || word_ready);
      capture       = ccff_shift_en;
      handshake     = word_valid_q && word_ready;
      last_bit      = (bitcnt_q == CNT_WIDTH'(CHAIN_LEN - 1));
      load          = capture && (pk_full || last_bit);
      pk_clear      = (state_q == IDLE) && start;
   end

   ccff_word_packer #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_packer (
      .clk       (prog_clk),
      .rst       (pReset),
      .clear     (pk_clear),
      .capture   (capture),
      .flush     (last_bit),
      .bit_in    (ccff_tail),
      .word_out  (pk_word),
      .word_full (pk_full)
   );

   // Next-state and output-register logic for the readback FSM.
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      word_cnt_d   = word_cnt_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      word_last_d  = word_last_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SHIFT;
               bitcnt_d   = '0;
               word_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (handshake) word_valid_d = 1'b0;
            if (capture) bitcnt_d = bitcnt_q + CNT_WIDTH'(1);
            if (load) begin
               word_data_d  = pk_word;
               word_valid_d = 1'b1;
               word_cnt_d   = word_cnt_q + WCNT_W'(1);
               if (word_cnt_q == WCNT_W'(WORD_COUNT - 1)) word_last_d = 1'b1;
            end
            if (capture && last_bit) state_d = DRAIN;
         end
         DRAIN: begin
            if (handshake) begin
               word_valid_d = 1'b0;
               word_last_d  = 1'b0;
               done_d       = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         word_cnt_q   <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         word_last_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         word_cnt_q   <= word_cnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         word_last_q  <= word_last_d;
         done_q       <= done_d;
      end
   end

   // Output mapping.
   always_comb begin
      word_data  = word_data_q;
      word_valid = word_valid_q;
      word_last  = word_last_q;
      done       = done_q;
      busy       = (state_q != IDLE);
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_ccff_chain_reader.sv
// Bench for ccff_chain_reader: three instances (chain 16, 10 and 1 bits, 8-bit
// words) driven one at a time against a word-list reference model.
module tb_ccff_chain_reader;
   import ccff_pkg::*;

   localparam int NDUT = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NDUT-1:0] start_v, tail_v, ready_v;
   logic [NDUT-1:0] shift_v, valid_v, last_v, busy_v, done_v;
   logic [7:0]      data_v [NDUT];
   ccff_state_e     dbg_v  [NDUT];

   function automatic int len_of(input int d);
      return (d == 0) ? 16 : ((d == 1) ? 10 : 1);
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ccff_chain_reader #(
         .CHAIN_LEN  ((g == 0) ? 16 : ((g == 1) ? 10 : 1)),
         .WORD_WIDTH (8)
      ) u_dut (
         .prog_clk      (clk),
         .pReset        (rst),
         .start         (start_v[g]),
         .ccff_tail     (tail_v[g]),
         .ccff_shift_en (shift_v[g]),
         .word_data     (data_v[g]),
         .word_valid    (valid_v[g]),
         .word_ready    (ready_v[g]),
         .word_last     (last_v[g]),
         .busy          (busy_v[g]),
         .done          (done_v[g]),
         .dbg_state     (dbg_v[g])
      );
   end

   // ---------------- scoreboard ----------------
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the chain is just a bit list; words are consecutive 8-bit
   // slices, LSB first, zero padded past the end of the chain.
   task automatic build_model(input logic [63:0] bits, input int len);
      int nw;
      logic [7:0] w;
      exp_q.delete();
      exp_last_q.delete();
      nw = (len + 7) / 8;
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int j = 0; j < 8; j++)
            if (k * 8 + j < len) w[j] = bits[k * 8 + j];
         exp_q.push_back(w);
         exp_last_q.push_back(k == nw - 1);
      end
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk({tag, "_data"},  64'(data_v[d]),  64'd0);
      chk({tag, "_valid"}, 64'(valid_v[d]), 64'd0);
      chk({tag, "_last"},  64'(last_v[d]),  64'd0);
      chk({tag, "_busy"},  64'(busy_v[d]),  64'd0);
      chk({tag, "_done"},  64'(done_v[d]),  64'd0);
      chk({tag, "_shift"}, 64'(shift_v[d]), 64'd0);
   endtask

   // ---------------- driver ----------------
   // mode 0: ready held high; 1: 5-cycle stall on first word; 2: random ready.
   task automatic run_read(input int d, input logic [63:0] bits, input int mode,
                           input bit poke_start);
      int len, ptr, cyc, shifts, dones, stall_left, done_cyc, extra;
      bit fin, stalled, prev_hold;
      logic [7:0] prev_data;
      len = len_of(d);
      build_model(bits, len);
      ptr = 0; cyc = 0; shifts = 0; dones = 0; stall_left = 0; done_cyc = 0;
      extra = 0; fin = 0; stalled = 0; prev_hold = 0; prev_data = '0;
      @(negedge clk);
      start_v[d] = 1'b1;
      ready_v[d] = 1'b1;
      tail_v[d]  = bits[0];
      @(posedge clk);
      while (!(fin && extra >= 3) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start_v[d] = poke_start && !fin && (cyc == 3 || last_v[d]);
         if (mode == 1 && valid_v[d] && !stalled) begin
            stalled    = 1'b1;
            stall_left = 5;
         end
         if (stall_left > 0) begin
            ready_v[d] = 1'b0;
            stall_left--;
         end else if (mode == 2) begin
            ready_v[d] = ($urandom_range(0, 3) != 0);
         end else begin
            ready_v[d] = 1'b1;
         end
         tail_v[d] = (ptr < len) ? bits[ptr] : 1'b0;
         #1;
         if (prev_hold) chk("stall_data", 64'(data_v[d]), 64'(prev_data));
         if (valid_v[d] && !ready_v[d]) chk("stall_shift", 64'(shift_v[d]), 64'd0);
         if (done_v[d]) begin
            dones++;
            if (!fin) done_cyc = cyc;
            fin = 1'b1;
         end
         chk("busy", 64'(busy_v[d]), 64'(!fin));
         if (valid_v[d] && ready_v[d]) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", 64'(data_v[d]), 64'hDEAD);
            end else begin
               chk("word_data", 64'(data_v[d]), 64'(exp_q.pop_front()));
               chk("word_last", 64'(last_v[d]), 64'(exp_last_q.pop_front()));
            end
         end
         if (shift_v[d]) begin
            ptr++;
            shifts++;
         end
         prev_hold = valid_v[d] && !ready_v[d];
         prev_data = data_v[d];
         if (fin) extra++;
      end
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
      chk("timeout", 64'(fin), 64'd1);
      chk("shift_count", 64'(shifts), 64'(len));
      chk("words_left", 64'(exp_q.size()), 64'd0);
      chk("done_pulses", 64'(dones), 64'd1);
      // cyc counts negedges after edge 0, so cycle c observes edge c-1.
      if (mode == 0) chk("done_edge", 64'(done_cyc - 1), 64'(len + 1));
   endtask

   task automatic reset_mid(input int d, input logic [63:0] bits);
      int ptr;
      ptr = 0;
      @(negedge clk);
      start_v[d] = 1'b1;
      ready_v[d] = 1'b1;
      tail_v[d]  = bits[0];
      @(posedge clk);
      for (int c = 0; c < 50 && ptr < 5; c++) begin
         @(negedge clk);
         start_v[d] = 1'b0;
         tail_v[d]  = bits[ptr];
         #1;
         if (shift_v[d]) ptr++;
      end
      chk("rst_bits_before", 64'(ptr), 64'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_shift_gate", 64'(shift_v[d]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_idle(d, "rst_mid");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk("rst_no_done", 64'(done_v[d]), 64'd0);
         chk("rst_no_busy", 64'(busy_v[d]), 64'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] bits;
      int d;
      rst     = 1'b1;
      start_v = '0;
      tail_v  = '0;
      ready_v = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) chk_idle(i, "reset");
      rst = 1'b0;

      // Basic: stream 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,1 -> 0x0D, 0x8F.
      run_read(0, 64'h8F0D, 0, 1'b0);
      // Partial final word: ten ones -> 0xFF, 0x03.
      run_read(1, 64'h3FF, 0, 1'b0);
      // Backpressure on the first word.
      bits = {$urandom, $urandom};
      run_read(0, bits, 1, 1'b0);
      bits = {$urandom, $urandom};
      run_read(1, bits, 1, 1'b0);
      // Reset mid-shift, then a clean full readback.
      bits = {$urandom, $urandom};
      reset_mid(0, bits);
      bits = {$urandom, $urandom};
      run_read(0, bits, 0, 1'b0);
      // Start pulses during SHIFT and DRAIN are ignored.
      bits = {$urandom, $urandom};
      run_read(0, bits, 0, 1'b1);
      // Single-bit chain.
      run_read(2, 64'h1, 0, 1'b0);
      // Random streams with random backpressure.
      for (int i = 0; i < 8; i++) begin
         d    = $urandom_range(0, NDUT - 1);
         bits = {$urandom, $urandom};
         run_read(d, bits, 2, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ccff_chain_reader.md
Name: ccff_chain_reader

Overview:
- Readback end of the configuration-chain (ccff) path: drives the chain's shift enable and samples the serial tail bit.
- Packs tail bits LSB-first into parallel words and hands them out over a valid/ready interface.
- Sits beside the chain loader in the programming domain and lets a host or bench read back the programmed bitstream for verification.

Parameters:
- CHAIN_LEN, 64, number of bits in the configuration chain (>= 1).
- WORD_WIDTH, 8, output word width (>= 1).
- CNT_WIDTH, $clog2(CHAIN_LEN+1), width of the bit counter (derived; not overridden).

Ports:
- prog_clk  input  1  programming clock; all state updates on its rising edge.
- pReset  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin readback; honoured only in IDLE.
- ccff_tail  input  1  serial bit from the chain tail, valid in every cycle.
- ccff_shift_en  output  1  chain advances one bit on each prog_clk edge where this is high.
- word_data  output  WORD_WIDTH  packed readback word; first-read bit in bit 0.
- word_valid  output  1  word_data holds an unconsumed word.
- word_ready  input  1  consumer accepts word_data when word_valid && word_ready.
- word_last  output  1  qualifies word_data as the final (possibly partial) word.
- busy  output  1  high in SHIFT and DRAIN.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (pReset sampled high at an edge):
  - state=IDLE; bit counter, word index and pack register cleared.
  - word_data=0; word_valid, word_last, busy and done = 0.
  - ccff_shift_en is also gated combinationally by !pReset, so the chain never shifts while reset is held.
  - Reset mid-operation aborts readback; no done pulse is produced.
- States:
  - IDLE: start=1 -> SHIFT at the next edge, counters cleared. start is ignored in SHIFT and DRAIN.
  - SHIFT:
    - ccff_shift_en = !pReset && (!word_valid || word_ready).
    - On each edge with ccff_shift_en=1, ccff_tail is written to pack bit position idx = bitcnt mod WORD_WIDTH, and bitcnt increments.
    - When a bit completes a word (idx = WORD_WIDTH-1) or is bit CHAIN_LEN-1, the completed word (including the new bit) loads word_data and word_valid=1 at the same edge. The pack register is cleared for the next word.
    - After bit CHAIN_LEN-1 is captured, word_last=1 and state -> DRAIN.
  - DRAIN: ccff_shift_en=0. On the handshake, word_valid=0, word_last=0, done=1 for one cycle, state -> IDLE.
- Backpressure:
  - A completed word waiting with word_ready=0 stalls the chain (ccff_shift_en=0), so no bit is lost.
  - A handshake and a new word load on the same edge is legal: the new word replaces the old and word_valid stays 1.
- Partial final word: bits above (CHAIN_LEN-1) mod WORD_WIDTH are 0.
- Latency, with word_ready held at 1 and start sampled at edge 0:
  - Bits are captured at edges 1..CHAIN_LEN; no bubbles.
  - Word k (0-based) is valid after edge (k+1)*WORD_WIDTH, or after edge CHAIN_LEN for the last word.
  - done is high after edge CHAIN_LEN+1.
- Word count = ceil(CHAIN_LEN/WORD_WIDTH).
- CHAIN_LEN=1 is legal: one word, word_last on the first word.

Decomposition:
- Shared package ccff_pkg holds:
  - state enum (IDLE, SHIFT, DRAIN);
  - the localparam for word count, ceil(CHAIN_LEN/WORD_WIDTH);
  - a helper function computing last-word valid-bit count.
- One natural sub-module: ccff_word_packer (pack register, idx counter, clear/load).
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Basic readback:
  - Stimulus: CHAIN_LEN=16, WORD_WIDTH=8, tail stream 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,1, ready=1.
  - Required: words 0x0D then 0x8F; word_last only on the second; done one cycle after edge 17; ccff_shift_en high for exactly 16 cycles.
- Partial word:
  - Stimulus: CHAIN_LEN=10, WORD_WIDTH=8, all tail bits=1.
  - Required: words 0xFF then 0x03 with word_last=1.
- Backpressure:
  - Stimulus: hold ready=0 for 5 cycles when the first word becomes valid.
  - Required: ccff_shift_en=0 during those 5 cycles, word_data stable, no tail bit dropped; the final words match the reference model.
- Reset mid-SHIFT:
  - Stimulus: assert pReset after 5 captured bits.
  - Required: ccff_shift_en=0 in the reset cycle; all outputs 0 after the edge; no done pulse; a fresh start reads the full chain correctly.
- Start while busy:
  - Stimulus: pulse start during SHIFT and during DRAIN.
  - Required: ignored; bit count and words unchanged; exactly one done pulse.
- Edge case CHAIN_LEN=1:
  - Stimulus: WORD_WIDTH=8, tail=1.
  - Required: single word 0x01 with word_last=1; done after edge 2.
